// File: rtl/eth_hdr_pkg.sv
// Shared types and constants for the Ethernet receive header stripper.
package eth_hdr_pkg;

  localparam int MAC_W     = 48;
  localparam int HDR_FLITS = 2;
  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Byte lanes of the header fields (lane 0 = bits 7:0, first on the wire)
  localparam int DST_LANE0    = 0;  // flit 0, lanes 0-5, MSB first
  localparam int SRC_HI_LANE0 = 6;  // flit 0, lanes 6-7
  localparam int SRC_LO_LANE0 = 2;  // flit 1, lanes 2-5
  localparam int DEST_LANE    = 6;  // flit 1, lane 6

  typedef struct packed {
    logic [MAC_W-1:0] dst_mac;
    logic [MAC_W-1:0] src_mac;
    logic [7:0]       dest;
  } eth_hdr_t;

  typedef enum logic [1:0] {
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  // Byte n of a 64-bit beat
  function automatic logic [7:0] lane(input logic [63:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  // Increment that sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry valid/ready output register: one cycle latency, full
// throughput when the consumer is always ready.
module axis_reg_slice #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  // Accept whenever the register is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  // Load on an input transfer, otherwise clear once the held beat is taken.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      // NOTE: the data register is cleared as well, so outputs read as zero
      // after reset instead of showing stale payload.
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_hdr_strip.sv
// Ethernet receive stage: parses two header flits, filters on destination
// MAC, strips the header and forwards payload with dest/source-MAC sideband.
module eth_rx_hdr_strip
  import eth_hdr_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEST_W  = 8,
  parameter bit PROMISC = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAC_W-1:0]    local_mac,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DEST_W-1:0]   m_dest,
  output logic [MAC_W-1:0]    m_src_mac,
  output logic [31:0]         rx_frames,
  output logic [31:0]         drop_frames
);

  rx_state_t       state, state_nxt;
  eth_hdr_t        hdr_in;
  logic [15:0]     src_hi_q;
  logic            match_q;
  logic            match_in;
  logic            sideband_busy;
  logic            hdr0_load, load_sideband;
  logic            rx_inc, drop_inc;
  logic            slice_in_valid, slice_in_ready;

  // Field view of the current beat; flit 0 supplies dst and the upper src
  // bytes, flit 1 supplies the lower src bytes and dest.
  always_comb begin
    hdr_in.dst_mac = {lane(s_data, DST_LANE0),     lane(s_data, DST_LANE0 + 1),
                      lane(s_data, DST_LANE0 + 2), lane(s_data, DST_LANE0 + 3),
                      lane(s_data, DST_LANE0 + 4), lane(s_data, DST_LANE0 + 5)};
    hdr_in.src_mac = {lane(s_data, SRC_HI_LANE0),     lane(s_data, SRC_HI_LANE0 + 1),
                      lane(s_data, SRC_LO_LANE0),     lane(s_data, SRC_LO_LANE0 + 1),
                      lane(s_data, SRC_LO_LANE0 + 2), lane(s_data, SRC_LO_LANE0 + 3)};
    hdr_in.dest    = lane(s_data, DEST_LANE);
  end

  assign match_in = PROMISC || (hdr_in.dst_mac == local_mac) ||
                    (hdr_in.dst_mac == BCAST_MAC);

  // Sideband may only change once the prior frame's final beat has left.
  assign sideband_busy = m_valid && !m_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_HDR0;
    else     state <= state_nxt;
  end

  // Next state, ingress ready and per-beat strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_nxt      = state;
    s_ready        = 1'b0;
    slice_in_valid = 1'b0;
    hdr0_load      = 1'b0;
    load_sideband  = 1'b0;
    rx_inc         = 1'b0;
    drop_inc       = 1'b0;
    case (state)
      ST_HDR0: begin
        s_ready = 1'b1;
        if (s_valid) begin
          hdr0_load = 1'b1;
          if (s_last) drop_inc  = 1'b1;
          else        state_nxt = ST_HDR1;
        end
      end
      ST_HDR1: begin
        s_ready = !(match_q && sideband_busy);
        if (s_valid && s_ready) begin
          if (s_last) begin
            drop_inc  = 1'b1;
            state_nxt = ST_HDR0;
          end else if (match_q) begin
            load_sideband = 1'b1;
            state_nxt     = ST_PAYLOAD;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        s_ready        = slice_in_ready;
        slice_in_valid = s_valid;
        if (s_valid && slice_in_ready && s_last) begin
          rx_inc    = 1'b1;
          state_nxt = ST_HDR0;
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          drop_inc  = 1'b1;
          state_nxt = ST_HDR0;
        end
      end
      default: state_nxt = ST_HDR0;
    endcase
  end

  // Header capture, frame sideband and saturating frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_hi_q    <= '0;
      match_q     <= 1'b0;
      m_dest      <= '0;
      m_src_mac   <= '0;
      rx_frames   <= '0;
      drop_frames <= '0;
    end else begin
      if (hdr0_load) begin
        src_hi_q <= hdr_in.src_mac[47:32];
        match_q  <= match_in;
      end
      if (load_sideband) begin
        m_dest    <= DEST_W'(hdr_in.dest);
        m_src_mac <= {src_hi_q, hdr_in.src_mac[31:0]};
      end
      if (rx_inc)   rx_frames   <= sat_inc(rx_frames);
      if (drop_inc) drop_frames <= sat_inc(drop_frames);
    end
  end

  axis_reg_slice #(.DATA_W(DATA_W)) u_out_slice (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s_data),
    .in_keep   (s_keep),
    .in_last   (s_last),
    .in_valid  (slice_in_valid),
    .in_ready  (slice_in_ready),
    .out_data  (m_data),
    .out_keep  (m_keep),
    .out_last  (m_last),
    .out_valid (m_valid),
    .out_ready (m_ready)
  );

endmodule

// File: tb/tb_eth_rx_hdr_strip.sv
// Scoreboard bench for eth_rx_hdr_strip: the stimulus thread queues the
// expected payload beats, a negedge monitor pops and compares them.
module tb_eth_rx_hdr_strip;

  localparam logic [47:0] LOCAL_MAC = 48'hfa16_3e55_ca02;
  localparam logic [47:0] SRC_MAC   = 48'h0cc4_7a88_c047;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] local_mac = LOCAL_MAC;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_dest;
  logic [47:0] m_src_mac;
  logic [31:0] rx_frames;
  logic [31:0] drop_frames;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  dest;
    logic [47:0] src;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stalls = 0;
  int          hold_cnt = 0;
  bit          toggle = 1'b0;
  bit          ignore = 1'b0;
  logic [63:0] pl_data[16];
  logic [7:0]  pl_keep[16];

  eth_rx_hdr_strip #(.DATA_W(64), .DEST_W(8), .PROMISC(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .local_mac   (local_mac),
    .s_data      (s_data),
    .s_keep      (s_keep),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_last      (m_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_dest      (m_dest),
    .m_src_mac   (m_src_mac),
    .rx_frames   (rx_frames),
    .drop_frames (drop_frames)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr0(input logic [47:0] dst, input logic [47:0] src);
    logic [63:0] d;
    for (int i = 0; i < 6; i++) d[8*i +: 8] = dst[8*(5-i) +: 8];
    d[55:48] = src[47:40];
    d[63:56] = src[39:32];
    return d;
  endfunction

  function automatic logic [63:0] mk_hdr1(input logic [47:0] src, input logic [7:0] dest);
    logic [63:0] d;
    d[15:0] = 16'ha5a5;
    for (int i = 0; i < 4; i++) d[8*(2+i) +: 8] = src[8*(3-i) +: 8];
    d[55:48] = dest;
    d[63:56] = 8'h5a;
    return d;
  endfunction

  // m_ready pattern: forced-low hold, alternating, or always ready.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (hold_cnt > 0) begin
        m_ready = 1'b0;
        hold_cnt--;
      end else if (toggle) begin
        m_ready = !m_ready;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: compare each output transfer to the scoreboard and check that
  // a stalled beat holds steady.
  exp_t prev_beat;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{m_data, m_keep, m_last, m_dest, m_src_mac};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", cur.data, prev_beat.data);
        check("stall_keep_last", {cur.keep, cur.last}, {prev_beat.keep, prev_beat.last});
        check("stall_sideband", {cur.dest, cur.src}, {prev_beat.dest, prev_beat.src});
      end
      if (m_valid && m_ready && !ignore) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %h with no beat expected", m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", cur.data, e.data);
          check("beat_keep", cur.keep, e.keep);
          check("beat_last", cur.last, e.last);
          check("beat_dest", cur.dest, e.dest);
          check("beat_src_mac", cur.src, e.src);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = cur;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stalls++;
      n++;
      if (n > 200) begin
        $display("FAIL s_ready_timeout: got no ready after %0d cycles expected ready", n);
        $fatal(1, "ingress stuck");
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [7:0] dest, input int n, input bit accept);
    send_beat(mk_hdr0(dst, src), 8'hff, 1'b0);
    send_beat(mk_hdr1(src, dest), 8'hff, n == 0);
    for (int i = 0; i < n; i++) begin
      if (accept) exp_q.push_back('{pl_data[i], pl_keep[i], i == n - 1, dest, src});
      send_beat(pl_data[i], pl_keep[i], i == n - 1);
    end
  endtask

  task automatic fill(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      pl_data[i] = base + 64'(i) * 64'h0101_0101_0101_0101;
      pl_keep[i] = (i == n - 1) ? 8'h3f : 8'hff;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_valid) begin
      errors++;
      $display("FAIL %s: got %0d beats still pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", m_data, 64'h0);
    check("reset_s_ready", s_ready, 1'b1);
    check("reset_rx_frames", rx_frames, 32'd0);
    check("reset_drop_frames", drop_frames, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: matching unicast frame, two payload beats
    pl_data[0] = 64'h0100_0001_0003_0000; pl_keep[0] = 8'hff;
    pl_data[1] = 64'h5073_9302_0000_0000; pl_keep[1] = 8'h0f;
    send_frame(LOCAL_MAC, SRC_MAC, 8'h00, 2, 1'b1);
    wait_drain("t1_drain");
    check("t1_rx_frames", rx_frames, 32'd1);
    check("t1_drop_frames", drop_frames, 32'd0);

    // 2: foreign MAC dropped without stalling, then broadcast accepted
    stalls = 0;
    send_frame(48'hfa16_3e55_ca03, SRC_MAC, 8'h00, 2, 1'b0);
    wait_drain("t2_drop_drain");
    check("t2_drop_no_stall", stalls, 0);
    check("t2_drop_frames", drop_frames, 32'd1);
    check("t2_rx_unchanged", rx_frames, 32'd1);
    send_frame(48'hffff_ffff_ffff, SRC_MAC, 8'h00, 2, 1'b1);
    wait_drain("t2_bcast_drain");
    check("t2_bcast_rx_frames", rx_frames, 32'd2);

    // Runt: s_last on flit 0
    send_beat(mk_hdr0(LOCAL_MAC, SRC_MAC), 8'hff, 1'b1);
    check("runt_drop_frames", drop_frames, 32'd2);

    // 3: header-only frame, then a normal frame
    send_frame(LOCAL_MAC, SRC_MAC, 8'h00, 0, 1'b1);
    wait_drain("t3_hdr_only_drain");
    check("t3_drop_frames", drop_frames, 32'd3);
    fill(3, 64'h1122_3344_5566_7788);
    send_frame(LOCAL_MAC, 48'h0200_0000_00aa, 8'h33, 3, 1'b1);
    wait_drain("t3_next_drain");
    check("t3_rx_frames", rx_frames, 32'd3);

    // 4: alternating m_ready over eight payload beats
    toggle = 1'b1;
    fill(8, 64'h0000_0000_0000_1000);
    send_frame(LOCAL_MAC, SRC_MAC, 8'h11, 8, 1'b1);
    wait_drain("t4_drain");
    toggle = 1'b0;
    check("t4_rx_frames", rx_frames, 32'd4);

    // 5: back-to-back frames, last beat of frame 1 held for five cycles
    @(posedge clk);
    #1;
    fill(4, 64'h0505_0000_0000_0000);
    send_frame(LOCAL_MAC, SRC_MAC, 8'h05, 4, 1'b1);
    hold_cnt = 5;
    stalls = 0;
    fill(3, 64'h0707_0000_0000_0000);
    send_frame(LOCAL_MAC, 48'h0c00_0000_0707, 8'h07, 3, 1'b1);
    wait_drain("t5_drain");
    check("t5_hdr1_stalled", stalls > 0, 1'b1);
    check("t5_rx_frames", rx_frames, 32'd6);

    // 6: reset for one cycle in the middle of a payload
    ignore = 1'b1;
    fill(4, 64'hdead_0000_0000_0000);
    send_beat(mk_hdr0(LOCAL_MAC, SRC_MAC), 8'hff, 1'b0);
    send_beat(mk_hdr1(SRC_MAC, 8'h44), 8'hff, 1'b0);
    send_beat(pl_data[0], pl_keep[0], 1'b0);
    send_beat(pl_data[1], pl_keep[1], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_m_valid", m_valid, 1'b0);
    check("t6_rx_frames", rx_frames, 32'd0);
    check("t6_drop_frames", drop_frames, 32'd0);
    check("t6_sideband", {m_dest, m_src_mac}, 56'h0);
    check("t6_s_ready", s_ready, 1'b1);
    ignore = 1'b0;
    fill(2, 64'h0606_0000_0000_0001);
    send_frame(LOCAL_MAC, SRC_MAC, 8'h06, 2, 1'b1);
    wait_drain("t6_drain");
    check("t6_rx_after", rx_frames, 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_hdr_strip.md
Name: eth_rx_hdr_strip

Overview:
- Receive-side stage directly downstream of the shell's 64-bit AXI-Stream Ethernet ingress.
- Consumes frames of two header flits followed by payload. Extracts destination MAC, source MAC and the Galapagos dest byte.
- Filters on destination MAC, strips both header flits, and forwards the payload with dest and source MAC as per-frame sideband to the router/kernel side.

Parameters:
- DATA_W, 64, stream data width; only 64 is supported.
- DEST_W, 8, width of the dest sideband.
- PROMISC, 0, 1 = accept every destination MAC.

Ports:
- clk  in  1  stream clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- local_mac  in  48  this node's MAC, quasi-static, sampled at HDR0.
- s_data  in  64  ingress data; byte lane 0 (bits 7:0) is first byte on wire.
- s_keep  in  8  ingress byte enables.
- s_last  in  1  ingress end of frame.
- s_valid  in  1  ingress valid.
- s_ready  out  1  ingress ready.
- m_data  out  64  payload data, unchanged lane order.
- m_keep  out  8  payload byte enables.
- m_last  out  1  payload end of frame.
- m_valid  out  1  payload valid.
- m_ready  in  1  payload ready.
- m_dest  out  8  dest byte of the current frame, stable for all beats of the frame.
- m_src_mac  out  48  source MAC of the current frame, stable for all beats of the frame.
- rx_frames  out  32  accepted frame count, saturating.
- drop_frames  out  32  dropped frame count, saturating.

Behaviour:
- Header layout, flit 0: lanes 0-5 = dst_mac[47:40]..dst_mac[7:0]; lanes 6-7 = src_mac[47:40], src_mac[39:32].
- Header layout, flit 1: lanes 0-1 = pad (ignored); lanes 2-5 = src_mac[31:24]..src_mac[7:0]; lane 6 = dest; lane 7 = reserved (ignored).
- A beat transfers when valid && ready. Header keep values are ignored.
- States: HDR0, HDR1, PAYLOAD, DROP. Reset state is HDR0.
- HDR0: s_ready=1.
  - On beat: latch dst and src-hi; compute match = PROMISC | (dst==local_mac) | (dst==48'hFFFF_FFFF_FFFF).
  - If s_last: drop_frames++, stay in HDR0 (runt). Else go to HDR1.
- HDR1: s_ready=1.
  - On beat: latch src-lo and dest.
  - If s_last: drop_frames++, go to HDR0 (header-only frame, nothing emitted).
  - Else if match: load m_dest/m_src_mac, go to PAYLOAD. Else go to DROP.
- PAYLOAD: single output register; s_ready = !m_valid | m_ready.
  - Each input beat loads m_data/m_keep/m_last and sets m_valid.
  - m_valid clears when m_ready and no new beat arrives.
  - On the input beat with s_last: rx_frames++, go to HDR0.
- m_dest/m_src_mac must not change while m_valid=1. A new frame's HDR1 update is deferred until the last output beat of the prior frame drains. HDR0/HDR1 may accept beats while that beat waits; HDR1 stalls (s_ready=0) only if it must overwrite sideband still held.
- DROP: s_ready=1, beats discarded; on s_last: drop_frames++, go to HDR0.
- Latency: first payload beat appears on m_* one cycle after its input transfer. Full throughput (1 beat/cycle) with m_ready=1.
- Backpressure: m_data/m_keep/m_last/m_valid hold while m_valid && !m_ready.
- Counters saturate at 32'hFFFF_FFFF. A drop and an accept never occur in the same cycle.
- Reset mid-frame: all state to HDR0; m_valid=0; m_data/m_keep/m_last/m_dest/m_src_mac=0; counters=0. Remaining beats of the interrupted frame are parsed as a new header. The upstream resets on the same rst, so this is accepted.
- local_mac changes take effect at the next HDR0 beat.

Decomposition:
- Package eth_hdr_pkg:
  - MAC_W=48, HDR_FLITS=2, BCAST_MAC constant.
  - Lane index constants for dst/src/dest fields.
  - typedef eth_hdr_t {dst_mac, src_mac, dest}.
  - Enum rx_state_t.
- One sub-module: axis_reg_slice (single-entry valid/ready output register) used for the PAYLOAD path.

Test Plan:
1. Frame dst=fa163e55ca02=local_mac, src=0cc47a88c047, dest=00; payload 0100000100030000 keep ff, then 5073930200000000 keep 0f last -> two m beats identical to input, m_dest=00, m_src_mac=0cc47a88c047, rx_frames=1.
2. Same frame with dst=fa163e55ca03 -> no m_valid; s_ready=1 throughout; drop_frames=1. Repeat with dst=ffffffffffff -> accepted, rx_frames increments.
3. Frame with s_last on flit 1 -> nothing emitted, drop_frames=1. Next normal frame is accepted correctly.
4. m_ready toggled 1010... over an 8-beat payload -> m_data sequence intact, no beat lost or duplicated, m_* stable during stalls.
5. Back-to-back frames, dest 05 then 07, m_ready held 0 for 5 cycles at the end of frame 1 -> frame 1's last beat shows m_dest=05; frame 2's beats all show 07.
6. rst asserted for 1 cycle in the middle of a payload -> next cycle m_valid=0, counters=0, state HDR0; a following clean frame is accepted.
